// File: rtl/fir_reload_core.sv
// Time-multiplexed single-MAC FIR with a shadow/active coefficient bank.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module fir_reload_core #(
  parameter int NTAPS = 8,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 32,
  parameter int ACCW  = DW + CW + $clog2(NTAPS)
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     coef_wr_en,
  input  logic [$clog2(NTAPS)-1:0] coef_wr_idx,
  input  logic [CW-1:0]            coef_wr_data,
  input  logic                     coef_commit,
  output logic                     coef_busy,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [DW-1:0]            s_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [OW-1:0]            m_tdata,
  output logic [31:0]              sample_cnt,
  output logic [1:0]               dbg_state
);

  localparam int KW = $clog2(NTAPS);
  localparam int PW = DW + CW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [CW-1:0]   r_shadow [NTAPS];
  logic signed [CW-1:0]   r_active [NTAPS];
  logic signed [DW-1:0]   r_dl     [NTAPS];
  logic signed [ACCW-1:0] r_acc;
  logic [KW-1:0]          r_k;
  logic                   r_commit_pend;
  logic [OW-1:0]          r_mdata;
  logic [31:0]            r_cnt;

  logic                   w_swap;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_out_hs;
  logic signed [PW-1:0]   w_coef_ext;
  logic signed [PW-1:0]   w_samp_ext;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_acc_next;
  logic [OW-1:0]          w_sat;

  assign w_swap   = (r_state == S_IDLE) && r_commit_pend;
  assign w_accept = (r_state == S_IDLE) && !r_commit_pend && s_tvalid;
  assign w_last   = (r_k == KW'(NTAPS - 1));
  assign w_out_hs = (r_state == S_OUT) && m_tready;

  // Full-precision product, sign-extended so NTAPS of them can never overflow the accumulator.
  assign w_coef_ext = {{DW{r_active[r_k][CW-1]}}, r_active[r_k]};
  assign w_samp_ext = {{CW{r_dl[r_k][DW-1]}}, r_dl[r_k]};
  assign w_prod     = w_coef_ext * w_samp_ext;
  assign w_acc_next = r_acc + {{(ACCW-PW){w_prod[PW-1]}}, w_prod};

  generate
    if (ACCW > OW) begin : g_sat
      logic w_ovf;
      assign w_ovf = !(&w_acc_next[ACCW-1:OW-1]) && (|w_acc_next[ACCW-1:OW-1]);
      always_comb begin
        w_sat = w_acc_next[OW-1:0];
        if (w_ovf) w_sat = w_acc_next[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
    end else begin : g_ext
      assign w_sat = OW'(w_acc_next);
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_MAC;
      S_MAC:   if (w_last)   w_state_next = S_OUT;
      S_OUT:   if (m_tready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_tready  = ARESETN && (r_state == S_IDLE) && !r_commit_pend;
    m_tvalid  = (r_state == S_OUT);
    coef_busy = r_commit_pend;
    dbg_state = r_state;
  end

  // The swap only fires in IDLE; a write landing in the swap cycle goes straight into active.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_commit_pend <= 1'b0;
    end else begin
      if (coef_wr_en) r_shadow[coef_wr_idx] <= coef_wr_data;
      if (w_swap) begin
        for (int i = 0; i < NTAPS; i++)
          r_active[i] <= (coef_wr_en && (coef_wr_idx == KW'(i))) ? coef_wr_data : r_shadow[i];
        r_commit_pend <= 1'b0;
      end else if (coef_commit) begin
        r_commit_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NTAPS; i++) r_dl[i] <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_mdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_dl[0] <= s_tdata;
        for (int i = 1; i < NTAPS; i++) r_dl[i] <= r_dl[i-1];
        r_acc <= '0;
        r_k   <= '0;
      end
      if (r_state == S_MAC) begin
        r_acc <= w_acc_next;
        r_k   <= r_k + 1'b1;
        if (w_last) r_mdata <= w_sat;
      end
      if (w_out_hs) r_cnt <= r_cnt + 32'd1;
    end
  end

  assign m_tdata    = r_mdata;
  assign sample_cnt = r_cnt;

endmodule
